// File: rtl/cmd_link_master_pkg.sv
// Shared constants and types for the cracker UART command/response link.
// Command word:  {device[2:0], cmd_num[4:0], payload[7:0]}, sent low byte first.
// Response word: {slave[2:0], resp_code[4:0], payload[31:0]}, received low byte first.
package cmd_link_master_pkg;

    localparam int unsigned CMD_BYTES      = 2;
    localparam int unsigned RESP_BYTES     = 5;
    localparam int unsigned RESP_SLAVE_LSB = 37;
    localparam int unsigned RESP_CODE_LSB  = 32;

    // Command and response codes shared with the slave firmware
    localparam logic [4:0] CMD_START     = 5'h01;
    localparam logic [4:0] CMD_STOP      = 5'h02;
    localparam logic [4:0] RESP_HIT      = 5'h02;
    localparam logic [4:0] RESP_FINISHED = 5'h03;

    typedef enum logic [1:0] {
        T_IDLE,
        T_B0,
        T_B1
    } tx_state_t;

    typedef struct packed {
        logic [2:0]  slave;
        logic [4:0]  code;
        logic [31:0] payload;
    } resp_t;

    // Extract the command number field from a command word
    function automatic logic [4:0] cmd_num_of(input logic [15:0] cmd);
        return cmd[12:8];
    endfunction

endpackage

// File: rtl/cmd_link_master_resp_asm.sv
// Response assembler: collects 5 UART bytes into one response word and drops
// a partial frame when the line stays idle for RX_TIMEOUT cycles mid-frame.
module cmd_link_resp_asm
    import cmd_link_master_pkg::*;
#(
    parameter int unsigned RX_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [7:0]  rx_byte,
    output logic        resp_valid,
    output logic [2:0]  resp_slave,
    output logic [4:0]  resp_code,
    output logic [31:0] resp_payload,
    output logic        frame_error
);

    localparam int unsigned CW = $clog2(RX_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(RX_TIMEOUT);

    logic [2:0]    idx;
    // Bytes 0..3 only; the final byte is taken straight from rx_byte on completion
    logic [31:0]   shreg;
    logic [CW-1:0] cnt;
    logic          timeout;
    logic [2:0]    wr_idx;
    logic [39:0]   word;

    // A byte arriving on the timeout cycle starts a fresh frame
    always_comb begin
        timeout = (idx != 3'd0) && (cnt == TMO);
        wr_idx  = timeout ? 3'd0 : idx;
        word    = {rx_byte, shreg};
    end

    // Byte capture, frame completion, and inter-byte timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            idx          <= '0;
            shreg        <= '0;
            cnt          <= '0;
            resp_valid   <= 1'b0;
            resp_slave   <= '0;
            resp_code    <= '0;
            resp_payload <= '0;
            frame_error  <= 1'b0;
        end else begin
            resp_valid  <= 1'b0;
            frame_error <= timeout;
            if (rx_ready) begin
                cnt <= '0;
                if (wr_idx == 3'(RESP_BYTES - 1)) begin
                    idx          <= '0;
                    resp_valid   <= 1'b1;
                    resp_slave   <= word[RESP_SLAVE_LSB +: 3];
                    resp_code    <= word[RESP_CODE_LSB +: 5];
                    resp_payload <= word[31:0];
                end else begin
                    shreg[{wr_idx[1:0], 3'b000} +: 8] <= rx_byte;
                    idx <= wr_idx + 3'd1;
                end
            end else if (timeout) begin
                idx <= '0;
                cnt <= '0;
            end else if (idx != 3'd0) begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cmd_link_master.sv
// Host-side command/response link master: serialises 16-bit commands into two
// UART bytes and reassembles 5-byte responses via cmd_link_resp_asm.
// Optional feature macro: CMD_LINK_STATS_EN adds hit_count and finished_mask.
module cmd_link_master
    import cmd_link_master_pkg::*;
#(
    parameter int unsigned RX_TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [15:0] cmd_data,
    output logic        cmd_ready,
    output logic [7:0]  uart_tx_byte,
    output logic        uart_tx_req,
    input  logic        uart_tx_busy,
    input  logic        uart_rx_ready,
    input  logic [7:0]  uart_rx_byte,
    output logic        resp_valid,
    output logic [2:0]  resp_slave,
    output logic [4:0]  resp_code,
    output logic [31:0] resp_payload,
    output logic        frame_error
`ifdef CMD_LINK_STATS_EN
    ,
    output logic [15:0] hit_count,
    output logic [7:0]  finished_mask
`endif
);

    tx_state_t   state, nxt;
    logic [15:0] cmd_q;
    logic        req_d;
    logic        accept;

    assign accept = cmd_valid && cmd_ready;

    // TX next state and outputs; the request is combinational so the first
    // byte can issue the cycle after accept, while req_d enforces a gap
    always_comb begin
        nxt          = state;
        cmd_ready    = 1'b0;
        uart_tx_req  = 1'b0;
        uart_tx_byte = '0;
        if (!reset) begin
            case (state)
                T_IDLE: begin
                    cmd_ready = 1'b1;
                    if (cmd_valid) nxt = T_B0;
                end
                T_B0: begin
                    uart_tx_byte = cmd_q[7:0];
                    if (!uart_tx_busy && !req_d) begin
                        uart_tx_req = 1'b1;
                        nxt         = T_B1;
                    end
                end
                T_B1: begin
                    uart_tx_byte = cmd_q[15:8];
                    if (!uart_tx_busy && !req_d) begin
                        uart_tx_req = 1'b1;
                        nxt         = T_IDLE;
                    end
                end
                default: nxt = T_IDLE;
            endcase
        end
    end

    // TX state register, command latch, and previous-cycle request flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= T_IDLE;
            cmd_q <= '0;
            req_d <= 1'b0;
        end else begin
            state <= nxt;
            req_d <= uart_tx_req;
            if (accept) cmd_q <= cmd_data;
        end
    end

    cmd_link_resp_asm #(
        .RX_TIMEOUT(RX_TIMEOUT)
    ) u_resp_asm (
        .clk          (clk),
        .reset        (reset),
        .rx_ready     (uart_rx_ready),
        .rx_byte      (uart_rx_byte),
        .resp_valid   (resp_valid),
        .resp_slave   (resp_slave),
        .resp_code    (resp_code),
        .resp_payload (resp_payload),
        .frame_error  (frame_error)
    );

`ifdef CMD_LINK_STATS_EN
    // Hit counter and finished-slave mask, cleared when a START is accepted
    always_ff @(posedge clk) begin
        if (reset || (accept && cmd_num_of(cmd_data) == CMD_START)) begin
            hit_count     <= '0;
            finished_mask <= '0;
        end else if (resp_valid) begin
            if (resp_code == RESP_HIT && hit_count != 16'hFFFF)
                hit_count <= hit_count + 16'd1;
            if (resp_code == RESP_FINISHED)
                finished_mask[resp_slave] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cmd_link_master.sv
// Self-checking bench for cmd_link_master, with a behavioural uart busy model
// and a frame-level reference model for the response assembler.
module tb_cmd_link_master;
    import cmd_link_master_pkg::*;

    localparam int unsigned T = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_data = '0;
    logic        cmd_ready;
    logic [7:0]  uart_tx_byte;
    logic        uart_tx_req;
    logic        uart_tx_busy = 1'b0;
    logic        uart_rx_ready = 1'b0;
    logic [7:0]  uart_rx_byte = '0;
    logic        resp_valid;
    logic [2:0]  resp_slave;
    logic [4:0]  resp_code;
    logic [31:0] resp_payload;
    logic        frame_error;
`ifdef CMD_LINK_STATS_EN
    logic [15:0] hit_count;
    logic [7:0]  finished_mask;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int busy_len = 0;
    int busy_left = 0;
    logic [39:0] rq[$];
    logic [39:0] exp_q[$];
    int exp_fe = 0;

    cmd_link_master #(.RX_TIMEOUT(T)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_data      (cmd_data),
        .cmd_ready     (cmd_ready),
        .uart_tx_byte  (uart_tx_byte),
        .uart_tx_req   (uart_tx_req),
        .uart_tx_busy  (uart_tx_busy),
        .uart_rx_ready (uart_rx_ready),
        .uart_rx_byte  (uart_rx_byte),
        .resp_valid    (resp_valid),
        .resp_slave    (resp_slave),
        .resp_code     (resp_code),
        .resp_payload  (resp_payload),
        .frame_error   (frame_error)
`ifdef CMD_LINK_STATS_EN
        ,
        .hit_count     (hit_count),
        .finished_mask (finished_mask)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Observe strobes mid-cycle
    always @(negedge clk) begin
        if (resp_valid) rq.push_back({resp_slave, resp_code, resp_payload});
        if (frame_error) fe_cnt++;
        if (uart_tx_req && busy_len > 0) busy_left = busy_len;
    end

    // uart transmitter model: busy rises the cycle after a request
    always begin
        @(posedge clk);
        #1;
        if (busy_left > 0) begin
            uart_tx_busy = 1'b1;
            busy_left--;
        end else begin
            uart_tx_busy = 1'b0;
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rx(input logic [7:0] b, input int gap);
        repeat (gap) step();
        uart_rx_ready = 1'b1;
        uart_rx_byte  = b;
        step();
        uart_rx_ready = 1'b0;
        uart_rx_byte  = 8'($urandom);
    endtask

    // Issue one command and check the two-byte serialisation and its timing
    task automatic run_cmd(input logic [15:0] d, input int bl);
        int acc, c1, c2, n, exp_c2;
        logic [7:0] b1, b2;
        bit ready_bad;
        logic ready_after, req_after;
        step();
        busy_len = bl;
        cmd_valid = 1'b1;
        cmd_data = d;
        acc = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                acc = cyc;
                break;
            end
        end
        step();
        cmd_valid = 1'b0;
        cmd_data = 16'($urandom);
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL cmd_accept: no accept within budget, cmd %h", d);
            return;
        end
        n = 0; c1 = -1; c2 = -1; b1 = '0; b2 = '0; ready_bad = 1'b0;
        // The accept cycle's negedge has already passed; begin at the next one
        for (int i = 0; i < 400 && n < 2; i++) begin
            if (i > 0 || 1) @(negedge clk);
            if (cmd_ready) ready_bad = 1'b1;
            if (uart_tx_req) begin
                if (n == 0) begin c1 = cyc; b1 = uart_tx_byte; end
                else begin c2 = cyc; b2 = uart_tx_byte; end
                n++;
            end
        end
        @(negedge clk);
        ready_after = cmd_ready;
        req_after = uart_tx_req;
        exp_c2 = acc + 2 + ((bl > 1) ? bl : 1);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL tx_req_count: got %0d want 2", n); end
        checks++;
        if (b1 !== d[7:0]) begin errors++; $display("FAIL tx_byte0: got %h want %h", b1, d[7:0]); end
        checks++;
        if (b2 !== d[15:8]) begin errors++; $display("FAIL tx_byte1: got %h want %h", b2, d[15:8]); end
        checks++;
        if (c1 !== acc + 1) begin errors++; $display("FAIL tx_first_latency: got %0d want %0d", c1 - acc, 1); end
        checks++;
        if (c2 !== exp_c2) begin errors++; $display("FAIL tx_second_cycle: got %0d want %0d (busy %0d)", c2 - acc, exp_c2 - acc, bl); end
        checks++;
        if (ready_bad) begin errors++; $display("FAIL cmd_ready_busy: got 1 want 0 before second byte"); end
        checks++;
        if (ready_after !== 1'b1 || req_after !== 1'b0) begin
            errors++;
            $display("FAIL tx_return_idle: ready %b req %b want 1 0", ready_after, req_after);
        end
        repeat (bl + 2) step();
        busy_len = 0;
    endtask

    // Random byte stream with gaps chosen around the timeout boundary
    task automatic rx_stream(input int nbytes);
        logic [7:0] part[$];
        int gap;
        logic [7:0] b;
        for (int k = 0; k < nbytes; k++) begin
            case ($urandom_range(0, 9))
                0: gap = T - 1;
                1: gap = T;
                2: gap = T + 4;
                3: gap = 3;
                4: gap = 1;
                default: gap = 0;
            endcase
            b = 8'($urandom);
            if (part.size() > 0 && gap >= int'(T)) begin
                exp_fe++;
                part.delete();
            end
            send_rx(b, gap);
            part.push_back(b);
            if (part.size() == RESP_BYTES) begin
                exp_q.push_back({part[4], part[3], part[2], part[1], part[0]});
                part.delete();
            end
        end
        if (part.size() > 0) exp_fe++;
        repeat (T + 5) step();
    endtask

    task automatic compare_rx(input string tag);
        checks++;
        if (rq.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL %s_resp_count: got %0d want %0d", tag, rq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < rq.size(); i++) begin
                checks++;
                if (rq[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL %s_resp[%0d]: got %h want %h", tag, i, rq[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (fe_cnt !== exp_fe) begin
            errors++;
            $display("FAIL %s_frame_error_count: got %0d want %0d", tag, fe_cnt, exp_fe);
        end
    endtask

    task automatic clear_rx();
        rq.delete();
        exp_q.delete();
        fe_cnt = 0;
        exp_fe = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        @(negedge clk);
        checks++;
        if ({cmd_ready, uart_tx_req, uart_tx_byte, resp_valid, resp_slave, resp_code, resp_payload, frame_error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready %b req %b byte %h rv %b slave %h code %h pl %h fe %b want all 0",
                     cmd_ready, uart_tx_req, uart_tx_byte, resp_valid, resp_slave, resp_code, resp_payload, frame_error);
        end
        step();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b want 1", cmd_ready); end
    endtask

    task automatic test_tx_basic();
        run_cmd(16'h2A5C, 0);
        run_cmd(16'h2A5C, 10);
    endtask

    task automatic test_rx_frame();
        clear_rx();
        send_rx(8'h78, 0);
        send_rx(8'h56, 0);
        send_rx(8'h34, 0);
        send_rx(8'h12, 0);
        send_rx(8'h25, 0);
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_slave !== 3'd1 || resp_code !== 5'h05 || resp_payload !== 32'h12345678) begin
            errors++;
            $display("FAIL rx_frame: rv %b slave %h code %h pl %h want 1 1 05 12345678", resp_valid, resp_slave, resp_code, resp_payload);
        end
        step();
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_payload !== 32'h12345678) begin
            errors++;
            $display("FAIL rx_hold: rv %b pl %h want 0 12345678", resp_valid, resp_payload);
        end
        clear_rx();
    endtask

    task automatic test_timeout();
        clear_rx();
        send_rx(8'hAA, 0);
        send_rx(8'hBB, 0);
        send_rx(8'hCC, 0);
        send_rx(8'hEF, T);
        send_rx(8'hBE, 0);
        send_rx(8'hAD, 0);
        send_rx(8'hDE, 0);
        send_rx(8'h40, 0);
        exp_q.push_back({3'd2, 5'd0, 32'hDEADBEEF});
        exp_fe = 1;
        repeat (3) step();
        compare_rx("timeout_edge");
        clear_rx();
        send_rx(8'h01, 0);
        send_rx(8'h02, 0);
        send_rx(8'h03, T - 1);
        send_rx(8'h04, 0);
        send_rx(8'hE7, 0);
        exp_q.push_back({8'hE7, 8'h04, 8'h03, 8'h02, 8'h01});
        repeat (3) step();
        compare_rx("timeout_below");
        clear_rx();
        send_rx(8'h11, 0);
        repeat (T + 5) step();
        exp_fe = 1;
        compare_rx("timeout_trailing");
        clear_rx();
    endtask

    task automatic test_reset_midflight();
        int reqs;
        int got;
        clear_rx();
        send_rx(8'h99, 0);
        send_rx(8'h88, 0);
        cmd_valid = 1'b1;
        cmd_data  = 16'hBEEF;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (uart_tx_req) begin got = 1; break; end
        end
        step();
        cmd_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (got !== 1 || uart_tx_req !== 1'b0 || cmd_ready !== 1'b0 || uart_tx_byte !== 8'h00) begin
            errors++;
            $display("FAIL reset_midflight_outputs: first_req %0d req %b ready %b byte %h want 1 0 0 00", got, uart_tx_req, cmd_ready, uart_tx_byte);
        end
        step();
        reset = 1'b0;
        reqs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (uart_tx_req) reqs++;
        end
        checks++;
        if (reqs !== 0 || rq.size() !== 0) begin
            errors++;
            $display("FAIL reset_discard: reqs %0d resps %0d want 0 0", reqs, rq.size());
        end
        step();
        send_rx(8'h10, 0);
        send_rx(8'h20, 0);
        send_rx(8'h30, 0);
        send_rx(8'h40, 0);
        send_rx(8'h65, 0);
        exp_q.push_back({8'h65, 8'h40, 8'h30, 8'h20, 8'h10});
        repeat (2) step();
        compare_rx("after_reset");
        clear_rx();
        run_cmd(16'h1357, 0);
    endtask

    task automatic test_back_to_back();
        clear_rx();
        fork
            begin
                for (int i = 0; i < 12; i++)
                    run_cmd(16'($urandom), int'($urandom_range(0, 5)));
            end
            rx_stream(60);
        join
        compare_rx("random");
        clear_rx();
    endtask

`ifdef CMD_LINK_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        step();
        reset = 1'b0;
        clear_rx();
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 4; j++) send_rx(8'($urandom), 0);
            send_rx({3'(i), RESP_HIT}, 0);
        end
        for (int j = 0; j < 4; j++) send_rx(8'($urandom), 0);
        send_rx({3'd3, RESP_FINISHED}, 0);
        repeat (2) step();
        @(negedge clk);
        checks++;
        if (hit_count !== 16'd3 || finished_mask !== 8'h08) begin
            errors++;
            $display("FAIL stats_count: hits %0d mask %h want 3 08", hit_count, finished_mask);
        end
        run_cmd({3'd0, CMD_START, 8'h11}, 0);
        checks++;
        if (hit_count !== 16'd0 || finished_mask !== 8'h00) begin
            errors++;
            $display("FAIL stats_clear: hits %0d mask %h want 0 00", hit_count, finished_mask);
        end
        clear_rx();
    endtask
`endif

    initial begin
        test_reset();
        test_tx_basic();
        test_rx_frame();
        test_timeout();
        test_reset_midflight();
        test_back_to_back();
`ifdef CMD_LINK_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
